// File: rtl/mdu_sequencer_if.sv
// E-stage MDU handshake bundle: control-unit requests in, HI/LO state and stall out.
// Cancel exists only when MDU_CANCEL_EN is defined.
interface mdu_sequencer_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 4
);
  logic             Start;
  logic [3:0]       MDUOP;
  logic [CNT_W-1:0] Time;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [1:0]       ReadHILO;
  logic             MDUseD;
`ifdef MDU_CANCEL_EN
  logic             Cancel;
`endif
  logic             Busy;
  logic             StallMD;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic [WIDTH-1:0] ReadData;

  modport slave (
    input  Start, MDUOP, Time, A, B, ReadHILO, MDUseD,
`ifdef MDU_CANCEL_EN
    input  Cancel,
`endif
    output Busy, StallMD, HI, LO, ReadData
  );

  modport master (
    output Start, MDUOP, Time, A, B, ReadHILO, MDUseD,
`ifdef MDU_CANCEL_EN
    output Cancel,
`endif
    input  Busy, StallMD, HI, LO, ReadData
  );
endinterface

// File: rtl/mdu_sequencer.sv
// Multiply/divide sequencer: computes on Start, holds the result for Time cycles, then commits
// to HI/LO. Optional exception flush input enabled by MDU_CANCEL_EN.
module mdu_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 4
) (
  input logic            clk,
  input logic            reset,
  mdu_sequencer_if.slave bus
);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;

  typedef enum logic {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] phi_q, phi_d, plo_q, plo_d;

  logic             is_md;
  logic             cancel;
  logic [CNT_W-1:0] time_eff;
  logic [2*WIDTH-1:0] res;

`ifdef MDU_CANCEL_EN
  assign cancel = bus.Cancel;
`else
  assign cancel = 1'b0;
`endif

  assign is_md    = (bus.MDUOP >= OpMult) && (bus.MDUOP <= OpDivu);
  assign time_eff = (bus.Time == '0) ? CNT_W'(1) : bus.Time;

  // Full-width result {hi, lo}; divide by zero yields {A, all ones} without trapping.
  always_comb begin
    res = '0;
    unique case (bus.MDUOP)
      OpMult:  res = $signed({{WIDTH{bus.A[WIDTH-1]}}, bus.A}) *
                     $signed({{WIDTH{bus.B[WIDTH-1]}}, bus.B});
      OpMultu: res = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};
      OpDiv: begin
        if (bus.B == '0) begin
          res = {bus.A, {WIDTH{1'b1}}};
        end else begin
          res[WIDTH-1:0]       = $signed(bus.A) / $signed(bus.B);
          res[2*WIDTH-1:WIDTH] = $signed(bus.A) % $signed(bus.B);
        end
      end
      OpDivu: begin
        if (bus.B == '0) begin
          res = {bus.A, {WIDTH{1'b1}}};
        end else begin
          res[WIDTH-1:0]       = bus.A / bus.B;
          res[2*WIDTH-1:WIDTH] = bus.A % bus.B;
        end
      end
      default: res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    if (cancel) begin
      state_d = StIdle;
      cnt_d   = '0;
      phi_d   = '0;
      plo_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.Start) begin
            if (is_md) begin
              state_d        = StRun;
              cnt_d          = time_eff;
              {phi_d, plo_d} = res;
            end else if (bus.MDUOP == OpMthi) begin
              hi_d = bus.A;
            end else if (bus.MDUOP == OpMtlo) begin
              lo_d = bus.A;
            end
          end
        end
        StRun: begin
          // Starts arriving here are ignored; the pending result is kept.
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = StIdle;
            hi_d    = phi_q;
            lo_d    = plo_q;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
    end
  end

  assign bus.Busy    = (state_q == StRun);
  // Includes the E-stage start of this cycle so back-to-back MD instructions stall.
  assign bus.StallMD = bus.MDUseD & (bus.Busy | (bus.Start & is_md));
  assign bus.HI      = hi_q;
  assign bus.LO      = lo_q;

  always_comb begin
    unique case (bus.ReadHILO)
      2'd1:    bus.ReadData = hi_q;
      2'd2:    bus.ReadData = lo_q;
      default: bus.ReadData = '0;
    endcase
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed cases plus randomized traffic against a
// cycle-stamped behavioural model of HI/LO and the pending result.
module tb_mdu_sequencer;

  logic clk;
  logic rst_n;

  mdu_sequencer_if #(.WIDTH(32), .CNT_W(4)) bus ();

  mdu_sequencer #(.WIDTH(32), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: architectural HI/LO, plus a pending result due to commit at the end of cycle m_done.
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  bit          m_pend;
  int          m_done;
  int          cyc;
  bit          allow_busy_start;

  function automatic bit md_op(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd4);
  endfunction

  function automatic bit m_busy();
    return m_pend && (cyc <= m_done);
  endfunction

  function automatic void compute(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] ph, output logic [31:0] pl);
    int signed sa, sb;
    longint signed ps;
    longint unsigned pu;
    sa = a;
    sb = b;
    ph = '0;
    pl = '0;
    case (op)
      4'd1: begin ps = longint'(sa) * longint'(sb); {ph, pl} = ps; end
      4'd2: begin pu = {32'h0, a} * {32'h0, b}; {ph, pl} = pu; end
      4'd3: if (b == 0) begin ph = a; pl = '1; end
            else begin pl = sa / sb; ph = sa % sb; end
      4'd4: if (b == 0) begin ph = a; pl = '1; end
            else begin pl = a / b; ph = a % b; end
      default: ;
    endcase
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic check_outputs();
    logic exp_stall;
    logic [31:0] exp_rd;
    exp_stall = bus.MDUseD & (m_busy() | (bus.Start & md_op(bus.MDUOP)));
    exp_rd = (bus.ReadHILO == 2'd1) ? m_hi : (bus.ReadHILO == 2'd2) ? m_lo : 32'h0;
    cmp("busy", 32'(bus.Busy), 32'(m_busy()));
    cmp("stall", 32'(bus.StallMD), 32'(exp_stall));
    cmp("hi", bus.HI, m_hi);
    cmp("lo", bus.LO, m_lo);
    cmp("readdata", bus.ReadData, exp_rd);
    if (bus.Start && m_busy() && !allow_busy_start) begin
      errors++;
      $display("FAIL start_while_busy at cycle %0d: got Start=1 expected no Start", cyc);
    end
  endtask

  task automatic model_edge();
    bit cancel_now;
    cancel_now = 1'b0;
`ifdef MDU_CANCEL_EN
    cancel_now = bus.Cancel;
`endif
    if (cancel_now) begin
      m_pend = 1'b0;
    end else if (m_busy()) begin
      if (cyc == m_done) begin
        m_hi   = m_phi;
        m_lo   = m_plo;
        m_pend = 1'b0;
      end
    end else if (bus.Start) begin
      if (md_op(bus.MDUOP)) begin
        compute(bus.MDUOP, bus.A, bus.B, m_phi, m_plo);
        m_pend = 1'b1;
        m_done = cyc + ((bus.Time == 0) ? 1 : int'(bus.Time));
      end else if (bus.MDUOP == 4'd5) begin
        m_hi = bus.A;
      end else if (bus.MDUOP == 4'd6) begin
        m_lo = bus.A;
      end
    end
    cyc++;
  endtask

  // Compare at the falling edge, advance the model, then return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    check_outputs();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] t);
    bus.Start = 1'b1;
    bus.MDUOP = op;
    bus.A     = a;
    bus.B     = b;
    bus.Time  = t;
    tick();
    bus.Start = 1'b0;
    bus.MDUOP = 4'd0;
  endtask

  task automatic model_reset();
    m_hi   = '0;
    m_lo   = '0;
    m_phi  = '0;
    m_plo  = '0;
    m_pend = 1'b0;
  endtask

  initial begin
    logic [31:0] save_hi, save_lo;
    cyc = 0;
    m_done = 0;
    allow_busy_start = 1'b0;
    model_reset();
    rst_n        = 1'b0;
    bus.Start    = 1'b0;
    bus.MDUOP    = 4'd0;
    bus.Time     = 4'd0;
    bus.A        = '0;
    bus.B        = '0;
    bus.ReadHILO = 2'd0;
    bus.MDUseD   = 1'b0;
`ifdef MDU_CANCEL_EN
    bus.Cancel   = 1'b0;
`endif
    #1;
    cmp("reset_busy", 32'(bus.Busy), 32'd0);
    cmp("reset_hi", bus.HI, 32'd0);
    cmp("reset_readdata", bus.ReadData, 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // MULT -3 * 7, Time 5: busy for exactly five cycles.
    bus.ReadHILO = 2'd2;
    issue(4'd1, 32'hFFFF_FFFD, 32'd7, 4'd5);
    repeat (5) begin
      cmp("mult_busy_window", 32'(bus.Busy), 32'd1);
      tick();
    end
    cmp("mult_busy_drop", 32'(bus.Busy), 32'd0);
    cmp("mult_hi", bus.HI, 32'hFFFF_FFFF);
    cmp("mult_lo", bus.LO, 32'hFFFF_FFEB);
    cmp("mult_readdata", bus.ReadData, 32'hFFFF_FFEB);

    // DIVU 100 / 7 and DIV -7 / 2.
    issue(4'd4, 32'd100, 32'd7, 4'd10);
    repeat (10) tick();
    cmp("divu_lo", bus.LO, 32'd14);
    cmp("divu_hi", bus.HI, 32'd2);
    issue(4'd3, 32'hFFFF_FFF9, 32'd2, 4'd10);
    repeat (10) tick();
    cmp("div_lo", bus.LO, 32'hFFFF_FFFD);
    cmp("div_hi", bus.HI, 32'hFFFF_FFFF);

    // Stall across a MULTU, with an ignored second start mid-run.
    bus.MDUseD = 1'b1;
    bus.Start = 1'b1;
    bus.MDUOP = 4'd2;
    bus.A = 32'd6;
    bus.B = 32'd7;
    bus.Time = 4'd5;
    #1 cmp("stall_start_cycle", 32'(bus.StallMD), 32'd1);
    tick();
    bus.Start = 1'b0;
    tick();
    allow_busy_start = 1'b1;
    issue(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2);
    allow_busy_start = 1'b0;
    repeat (3) begin
      cmp("stall_busy", 32'(bus.StallMD), 32'd1);
      tick();
    end
    cmp("stall_after", 32'(bus.StallMD), 32'd0);
    cmp("multu_first_only_lo", bus.LO, 32'd42);
    cmp("multu_first_only_hi", bus.HI, 32'd0);
    bus.MDUseD = 1'b0;

    // MTHI while idle, then divide by zero.
    bus.ReadHILO = 2'd1;
    issue(4'd5, 32'h1234_5678, 32'd0, 4'd0);
    cmp("mthi_hi", bus.HI, 32'h1234_5678);
    cmp("mthi_busy", 32'(bus.Busy), 32'd0);
    cmp("mthi_readdata", bus.ReadData, 32'h1234_5678);
    issue(4'd3, 32'd5, 32'd0, 4'd10);
    repeat (10) tick();
    cmp("div0_hi", bus.HI, 32'd5);
    cmp("div0_lo", bus.LO, 32'hFFFF_FFFF);

    // Reset asserted while a DIV has three cycles left.
    issue(4'd3, 32'd1000, 32'd3, 4'd10);
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    cmp("rst_mid_busy", 32'(bus.Busy), 32'd0);
    cmp("rst_mid_hi", bus.HI, 32'd0);
    cmp("rst_mid_lo", bus.LO, 32'd0);
    rst_n = 1'b1;
    repeat (6) tick();
    cmp("rst_no_commit_lo", bus.LO, 32'd0);

`ifdef MDU_CANCEL_EN
    issue(4'd6, 32'hCAFE_0001, 32'd0, 4'd0);
    save_hi = bus.HI;
    save_lo = bus.LO;
    issue(4'd1, 32'd9, 32'd9, 4'd5);
    tick();
    bus.Cancel = 1'b1;
    tick();
    bus.Cancel = 1'b0;
    cmp("cancel_busy", 32'(bus.Busy), 32'd0);
    repeat (5) tick();
    cmp("cancel_hi", bus.HI, save_hi);
    cmp("cancel_lo", bus.LO, save_lo);
    bus.Cancel = 1'b1;
    issue(4'd2, 32'd3, 32'd3, 4'd5);
    bus.Cancel = 1'b0;
    cmp("cancel_start_busy", 32'(bus.Busy), 32'd0);
`else
    save_hi = '0;
    save_lo = '0;
`endif

    // Randomized traffic; starts only while the model says the unit is idle.
    for (int i = 0; i < 800; i++) begin
      bus.Start    = 1'b0;
      bus.MDUOP    = 4'($urandom_range(0, 15));
      bus.A        = $urandom;
      bus.B        = ($urandom_range(0, 7) == 0) ? 32'd0 :
                     ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 50)) : $urandom;
      bus.Time     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                 : 4'($urandom_range(0, 5));
      bus.ReadHILO = 2'($urandom_range(0, 3));
      bus.MDUseD   = 1'($urandom_range(0, 1));
      if (!m_busy() && ($urandom_range(0, 2) == 0)) begin
        bus.Start = 1'b1;
        bus.MDUOP = 4'($urandom_range(0, 8));
      end
      if (bus.A == 32'h8000_0000 && bus.B == 32'hFFFF_FFFF) bus.B = 32'd1;
`ifdef MDU_CANCEL_EN
      bus.Cancel = ($urandom_range(0, 19) == 0);
`endif
      tick();
    end
    bus.Start = 1'b0;
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
